act_feeder: RTL and testbench

Upstream stage of seq_acc. Accepts a narrow stream of activation beats and packs them into one full row vector of inputElements x maxInputBits. Extends each element to maxInputBits according to cfg, then presents the vector on the seq_acc mac_data_i/mac_valid_i/ready_o handshake. A two-entry vector buffer lets the next vector fill while seq_acc consumes the current one.

---
 rtl/qracc_pkg.sv | 19 +
 rtl/act_sign_ext.sv | 28 ++
 rtl/act_feeder.sv | 106 ++++++++++
 tb/tb_act_feeder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qracc_pkg.sv
// Shared types and constants for the QR accelerator datapath.
package qracc_pkg;

   localparam int unsigned NB_CFG_W          = 4;
   localparam int unsigned ACT_BEAT_ELEMENTS = 8;
   localparam int unsigned VEC_COUNT_W       = 16;

   typedef struct packed {
      logic [NB_CFG_W-1:0] n_input_bits_cfg;
      logic                unsigned_acts;
   } qracc_config_t;

   typedef enum logic [1:0] {
      StEmpty,
      StOne,
      StFull
   } feed_occ_e;

endpackage

// File: rtl/act_sign_ext.sv
// Extends one activation element of nb significant bits to the full stored width.
module act_sign_ext
   import qracc_pkg::*;
#(
   parameter int unsigned maxInputBits = 4
) (
   input  logic [maxInputBits-1:0] elem,
   input  logic [NB_CFG_W-1:0]     nb,
   input  logic                    unsigned_acts,
   output logic [maxInputBits-1:0] ext
);

   int unsigned eff;

   always_comb begin
      eff = maxInputBits;
      if (nb != '0 && 32'(nb) <= maxInputBits) begin
         eff = 32'(nb);
      end
      ext = elem;
      for (int unsigned i = 0; i < maxInputBits; i++) begin
         if (i >= eff) begin
            ext[i] = unsigned_acts ? 1'b0 : elem[eff-1];
         end
      end
   end

endmodule

// File: rtl/act_feeder.sv
// Packs narrow activation beats into full MAC row vectors, double-buffered
// so one vector can fill while the consumer drains the other.
module act_feeder
   import qracc_pkg::*;
#(
   parameter int unsigned inputElements = 128,
   parameter int unsigned maxInputBits  = 4,
   parameter int unsigned beatElements  = ACT_BEAT_ELEMENTS
) (
   input  logic                                         clk,
   input  logic                                         nrst,
   input  qracc_config_t                                cfg,
   input  logic [beatElements*maxInputBits-1:0]         s_data_i,
   input  logic                                         s_valid_i,
   input  logic                                         s_last_i,
   output logic                                         s_ready_o,
   output logic [inputElements-1:0][maxInputBits-1:0]   mac_data_o,
   output logic                                         mac_valid_o,
   input  logic                                         mac_ready_i,
   output logic [VEC_COUNT_W-1:0]                       vec_count_o
);

   localparam int unsigned numBeats = inputElements / beatElements;
   localparam int unsigned BeatW    = (numBeats > 1) ? $clog2(numBeats) : 1;

   feed_occ_e                                  occ_q, occ_d;
   logic                                       wr_sel_q, rd_sel_q;
   logic [BeatW-1:0]                           beat_cnt_q;
   logic [VEC_COUNT_W-1:0]                     vec_count_q;
   logic [inputElements-1:0][maxInputBits-1:0] vbuf_q [2];
   logic [beatElements-1:0][maxInputBits-1:0]  beat_ext;
   logic                                       accept, commit, pop, last_beat;

   for (genvar k = 0; k < beatElements; k++) begin : g_ext
      act_sign_ext #(
         .maxInputBits (maxInputBits)
      ) u_ext (
         .elem          (s_data_i[k*maxInputBits +: maxInputBits]),
         .nb            (cfg.n_input_bits_cfg),
         .unsigned_acts (cfg.unsigned_acts),
         .ext           (beat_ext[k])
      );
   end

   assign s_ready_o   = (occ_q != StFull);
   assign mac_valid_o = (occ_q != StEmpty);
   assign mac_data_o  = vbuf_q[rd_sel_q];
   assign vec_count_o = vec_count_q;

   assign accept    = s_valid_i & s_ready_o;
   assign last_beat = (32'(beat_cnt_q) == numBeats - 1);
   assign commit    = accept & (last_beat | s_last_i);
   assign pop       = mac_valid_o & mac_ready_i;

   always_comb begin
      occ_d = occ_q;
      case ({commit, pop})
         2'b10:   occ_d = (occ_q == StEmpty) ? StOne : StFull;
         2'b01:   occ_d = (occ_q == StFull) ? StOne : StEmpty;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         occ_q       <= StEmpty;
         wr_sel_q    <= 1'b0;
         rd_sel_q    <= 1'b0;
         beat_cnt_q  <= '0;
         vec_count_q <= '0;
      end else begin
         occ_q <= occ_d;
         if (commit) begin
            beat_cnt_q <= '0;
            wr_sel_q   <= ~wr_sel_q;
         end else if (accept) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
         end
         if (pop) begin
            rd_sel_q    <= ~rd_sel_q;
            vec_count_q <= vec_count_q + 1'b1;
         end
      end
   end

   // First beat of a vector clears the rest of the entry so short vectors read zero-padded.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         vbuf_q[0] <= '0;
         vbuf_q[1] <= '0;
      end else if (accept) begin
         for (int unsigned b = 0; b < 2; b++) begin
            if (1'(b) == wr_sel_q) begin
               for (int unsigned r = 0; r < inputElements; r++) begin
                  if ((r / beatElements) == 32'(beat_cnt_q)) begin
                     vbuf_q[b][r] <= beat_ext[r % beatElements];
                  end else if (beat_cnt_q == '0) begin
                     vbuf_q[b][r] <= '0;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_act_feeder.sv
// Directed and randomized bench for act_feeder against a row-array reference model.
module tb_act_feeder;
   import qracc_pkg::*;

   localparam int unsigned IE  = 128;
   localparam int unsigned MB  = 4;
   localparam int unsigned BE  = 8;
   localparam int unsigned NBT = IE / BE;

   logic                   clk = 1'b0;
   logic                   nrst;
   qracc_config_t          cfg;
   logic [BE*MB-1:0]       s_data_i;
   logic                   s_valid_i, s_last_i, s_ready_o;
   logic [IE-1:0][MB-1:0]  mac_data_o;
   logic                   mac_valid_o, mac_ready_i;
   logic [15:0]            vec_count_o;

   act_feeder #(
      .inputElements (IE),
      .maxInputBits  (MB),
      .beatElements  (BE)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .cfg         (cfg),
      .s_data_i    (s_data_i),
      .s_valid_i   (s_valid_i),
      .s_last_i    (s_last_i),
      .s_ready_o   (s_ready_o),
      .mac_data_o  (mac_data_o),
      .mac_valid_o (mac_valid_o),
      .mac_ready_i (mac_ready_i),
      .vec_count_o (vec_count_o)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [511:0] exp_q[$];
   int         cur_rows[IE];
   int         mdl_beat = 0;
   int         exp_vc = 0;
   bit         rand_ready = 0;
   bit         held = 0;
   logic [31:0] pat;
   int         base;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Keep nb low bits, then interpret as signed or unsigned and re-wrap to MB bits.
   function automatic int model_ext(int raw, int nb, bit uns);
      int eff, v;
      eff = (nb == 0 || nb > MB) ? MB : nb;
      v = raw % (1 << eff);
      if (!uns && v >= (1 << (eff - 1))) v -= (1 << eff);
      return (v + (1 << MB)) % (1 << MB);
   endfunction

   function automatic logic [511:0] pack_rows();
      logic [511:0] v = '0;
      for (int r = 0; r < IE; r++) v[r*MB +: MB] = MB'(cur_rows[r]);
      return v;
   endfunction

   task automatic send_beat(input logic [31:0] data, input bit last);
      bit got = 0;
      s_data_i  = data;
      s_last_i  = last;
      s_valid_i = 1'b1;
      if (rand_ready) mac_ready_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         got = s_ready_o;
         @(posedge clk);
         #1;
         if (!got && rand_ready) mac_ready_i = 1'($urandom_range(0, 1));
      end
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
      check("beat_accepted", got, 1);
      if (!got) return;
      if (mdl_beat == 0) foreach (cur_rows[r]) cur_rows[r] = 0;
      for (int k = 0; k < BE; k++)
         cur_rows[mdl_beat*BE + k] = model_ext(int'(data[k*MB +: MB]),
                                               int'(cfg.n_input_bits_cfg), cfg.unsigned_acts);
      if (mdl_beat == NBT - 1 || last) begin
         exp_q.push_back(pack_rows());
         mdl_beat = 0;
         exp_vc++;
      end else begin
         mdl_beat++;
      end
   endtask

   task automatic send_vec(input int nbeats, input logic [31:0] p, input bit rnd, input bit last_end);
      for (int b = 0; b < nbeats; b++)
         send_beat(rnd ? $urandom : p, last_end && (b == nbeats - 1));
   endtask

   task automatic drain();
      mac_ready_i = 1'b1;
      for (int i = 0; i < 300 && (exp_q.size() != 0 || mac_valid_o); i++) begin
         @(posedge clk);
         #1;
      end
      check("drain_valid_low", mac_valid_o, 0);
      check("drain_model_empty", exp_q.size(), 0);
      check("drain_vec_count", vec_count_o, exp_vc & 16'hFFFF);
   endtask

   // Every presented vector must match the model head; valid must persist until popped.
   always @(negedge clk) begin
      if (nrst !== 1'b1) begin
         held = 0;
      end else begin
         if (held) check("valid_held", mac_valid_o, 1);
         if (mac_valid_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_vector", mac_valid_o, 0);
            end else begin
               check("vec_data", mac_data_o, exp_q[0]);
               if (mac_ready_i) void'(exp_q.pop_front());
            end
         end
         held = mac_valid_o && !mac_ready_i;
      end
   end

   initial begin
      nrst = 1'b0;
      cfg.n_input_bits_cfg = 4'd4;
      cfg.unsigned_acts = 1'b0;
      s_data_i = '0;
      s_valid_i = 1'b0;
      s_last_i = 1'b0;
      mac_ready_i = 1'b1;
      #1;
      check("rst_s_ready", s_ready_o, 1);
      check("rst_mac_valid", mac_valid_o, 0);
      check("rst_mac_data", mac_data_o, 0);
      check("rst_vec_count", vec_count_o, 0);
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_valid", mac_valid_o, 0);

      // Full signed vector, row r holds r % 8
      for (int k = 0; k < BE; k++) pat[k*MB +: MB] = MB'(k);
      for (int b = 0; b < NBT; b++) begin
         send_beat(pat, 1'b0);
         if (b == NBT - 2) check("valid_before_commit", mac_valid_o, 0);
      end
      check("valid_after_commit", mac_valid_o, 1);
      check("row5", mac_data_o[5], 4'd5);
      check("row127", mac_data_o[127], 4'd7);
      @(posedge clk);
      #1;
      check("first_vec_count", vec_count_o, 1);
      check("first_valid_low", mac_valid_o, 0);

      // Extension at nb=2: low elements 4'b1110, high elements 4'b0101
      cfg.n_input_bits_cfg = 4'd2;
      cfg.unsigned_acts = 1'b0;
      send_beat(32'h5555_EEEE, 1'b1);
      check("sext_1110", mac_data_o[0], 4'b1110);
      check("sext_0101", mac_data_o[4], 4'b0001);
      check("sext_pad", mac_data_o[8], 4'b0000);
      cfg.unsigned_acts = 1'b1;
      send_beat(32'h5555_EEEE, 1'b1);
      check("zext_1110", mac_data_o[0], 4'b0010);
      check("zext_0101", mac_data_o[4], 4'b0001);
      drain();

      // Early last lands in the buffer previously holding an all-7 vector
      cfg.n_input_bits_cfg = 4'd4;
      cfg.unsigned_acts = 1'b0;
      send_vec(NBT, 32'h7777_7777, 1'b0, 1'b0);
      send_vec(1, 32'h0, 1'b1, 1'b1);
      send_vec(3, 32'h1111_1111, 1'b0, 1'b1);
      check("early_row23", mac_data_o[23], 4'h1);
      check("early_row24", mac_data_o[24], 4'h0);
      check("early_row127", mac_data_o[127], 4'h0);
      drain();

      // Back-pressure: third vector stalls until the consumer wakes
      base = exp_vc;
      mac_ready_i = 1'b0;
      send_vec(NBT, 32'h0, 1'b1, 1'b0);
      send_vec(NBT, 32'h0, 1'b1, 1'b1);
      check("bp_s_ready_low", s_ready_o, 0);
      check("bp_valid", mac_valid_o, 1);
      fork
         send_vec(NBT, 32'h0, 1'b1, 1'b0);
         begin
            repeat (8) @(posedge clk);
            #1;
            check("bp_still_full", s_ready_o, 0);
            check("bp_vc_held", vec_count_o, base & 16'hFFFF);
            mac_ready_i = 1'b1;
         end
      join
      drain();
      check("bp_three_out", exp_vc - base, 3);

      // Commit and pop in the same cycle with one vector pending
      base = exp_vc;
      mac_ready_i = 1'b0;
      send_vec(NBT, 32'h0, 1'b1, 1'b0);
      send_vec(NBT - 1, 32'h0, 1'b1, 1'b0);
      mac_ready_i = 1'b1;
      send_beat($urandom, 1'b0);
      check("simul_valid", mac_valid_o, 1);
      check("simul_s_ready", s_ready_o, 1);
      check("simul_vc", vec_count_o, (base + 1) & 16'hFFFF);
      drain();

      // Reset mid-fill with one vector buffered
      mac_ready_i = 1'b0;
      send_vec(NBT, 32'h0, 1'b1, 1'b0);
      send_vec(7, 32'h0, 1'b1, 1'b0);
      nrst = 1'b0;
      exp_q.delete();
      mdl_beat = 0;
      exp_vc = 0;
      #1;
      check("mid_rst_valid", mac_valid_o, 0);
      check("mid_rst_vc", vec_count_o, 0);
      check("mid_rst_s_ready", s_ready_o, 1);
      check("mid_rst_data", mac_data_o, 0);
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      mac_ready_i = 1'b1;
      send_vec(NBT, 32'h0, 1'b1, 1'b1);
      drain();

      // Randomized beats, configs, early lasts and consumer stalls
      rand_ready = 1;
      for (int i = 0; i < 400; i++) begin
         cfg.n_input_bits_cfg = 4'($urandom_range(0, 15));
         cfg.unsigned_acts = 1'($urandom_range(0, 1));
         send_beat($urandom, $urandom_range(0, 9) == 0);
      end
      rand_ready = 0;
      if (mdl_beat != 0) send_beat($urandom, 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
